// File: rtl/counter_pkg.sv
// Shared constants for the multi-channel range counter.
// Mode/direction encodings and default geometry.
package counter_pkg;
   localparam logic MODE_WRAP = 1'b0;
   localparam logic MODE_SAT  = 1'b1;
   localparam logic DIR_UP    = 1'b1;
   localparam logic DIR_DN    = 1'b0;

   localparam int W_DEF    = 4;
   localparam int KMIN_DEF = 1;
   localparam int KMAX_DEF = 2**W_DEF - 1;
endpackage

// File: rtl/counter_chan.sv
// One counter channel: clamped load, wrap/saturate stepping, terminal-count pulse.
// One cycle from ld/en to cnt/tc; no backpressure, a step is taken every enabled cycle.
module counter_chan
   import counter_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int KMIN = KMIN_DEF,
   parameter int KMAX = KMAX_DEF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         en,
   input  logic         dir,
   input  logic         sat,
   input  logic         ld,
   input  logic [W-1:0] ld_val,
   output logic [W-1:0] cnt,
   output logic         tc,
   output logic         in_range
);
   // One guard bit so cnt+1 at the top of the counter cannot overflow.
   localparam logic [W:0] LO = (W+1)'(KMIN);
   localparam logic [W:0] HI = (W+1)'(KMAX);

   logic [W:0] cur;
   logic [W:0] ldw;
   logic [W:0] nxt;
   logic       tc_nxt;

   assign cur      = {1'b0, cnt};
   assign ldw      = {1'b0, ld_val};
   assign in_range = (cur >= LO) && (cur <= HI);

   always_comb begin
      nxt    = cur;
      tc_nxt = 1'b0;
      if (ld) begin
         if (ldw < LO)      nxt = LO;
         else if (ldw > HI) nxt = HI;
         else               nxt = ldw;
      end else if (en) begin
         if (dir == DIR_UP) begin
            if (cur >= HI) begin
               tc_nxt = 1'b1;
               nxt    = (sat == MODE_SAT) ? HI : LO;
            end else begin
               nxt = cur + 1'b1;
            end
         end else begin
            if (cur <= LO) begin
               tc_nxt = 1'b1;
               nxt    = (sat == MODE_SAT) ? LO : HI;
            end else begin
               nxt = cur - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= LO[W-1:0];
         tc  <= 1'b0;
      end else begin
         cnt <= nxt[W-1:0];
         tc  <= tc_nxt;
      end
   end
endmodule

// File: rtl/multi_range_counter.sv
// NCH independent range counters sharing clk/rst; prop flags all counts in [KMIN,KMAX].
// One cycle from ld/en to cnt/tc; no backpressure.
module multi_range_counter
   import counter_pkg::*;
#(
   parameter int W    = W_DEF,
   parameter int NCH  = 2,
   parameter int KMIN = KMIN_DEF,
   parameter int KMAX = 2**W - 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH-1:0]   en,
   input  logic [NCH-1:0]   dir,
   input  logic [NCH-1:0]   sat,
   input  logic [NCH-1:0]   ld,
   input  logic [NCH*W-1:0] ld_val,
   output logic [NCH*W-1:0] cnt,
   output logic [NCH-1:0]   tc,
   output logic             prop
);
   generate
      if (!(KMIN < KMAX && KMAX <= 2**W - 1 && NCH >= 1)) begin : g_bad_params
         $fatal(1, "multi_range_counter: need KMIN < KMAX <= 2**W-1 and NCH >= 1");
      end
   endgenerate

   logic [NCH-1:0] in_rng;

   for (genvar i = 0; i < NCH; i++) begin : g_chan
      counter_chan #(.W(W), .KMIN(KMIN), .KMAX(KMAX)) u_chan (
         .clk      (clk),
         .rst      (rst),
         .en       (en[i]),
         .dir      (dir[i]),
         .sat      (sat[i]),
         .ld       (ld[i]),
         .ld_val   (ld_val[i*W +: W]),
         .cnt      (cnt[i*W +: W]),
         .tc       (tc[i]),
         .in_range (in_rng[i])
      );
   end

   assign prop = &in_rng;

   prop_a: assert property (@(posedge clk) disable iff (rst) prop);
endmodule

// File: tb/tb_multi_range_counter.sv
// Directed scenarios then randomized traffic, checked against a range-arithmetic model.
module tb_multi_range_counter;
   localparam int W    = 4;
   localparam int NCH  = 2;
   localparam int KMIN = 1;
   localparam int KMAX = 15;
   localparam int R    = KMAX - KMIN + 1;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [NCH-1:0]   en  = '0;
   logic [NCH-1:0]   dir = '0;
   logic [NCH-1:0]   sat = '0;
   logic [NCH-1:0]   ld  = '0;
   logic [NCH*W-1:0] ld_val = '0;
   logic [NCH*W-1:0] cnt;
   logic [NCH-1:0]   tc;
   logic             prop;

   int n_cmp = 0;
   int n_err = 0;
   int m_cnt [NCH];
   int m_tc  [NCH];
   int tc0_seen;

   multi_range_counter #(.W(W), .NCH(NCH), .KMIN(KMIN), .KMAX(KMAX)) dut (
      .clk    (clk),
      .rst    (rst),
      .en     (en),
      .dir    (dir),
      .sat    (sat),
      .ld     (ld),
      .ld_val (ld_val),
      .cnt    (cnt),
      .tc     (tc),
      .prop   (prop)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int c = 0; c < NCH; c++) begin
         m_cnt[c] = KMIN;
         m_tc[c]  = 0;
      end
   endtask

   // Counts live in the ring KMIN..KMAX; wrap is modular, saturate is a clamp.
   task automatic model_step();
      for (int c = 0; c < NCH; c++) begin
         int lv, s, raw;
         lv = int'(ld_val[c*W +: W]);
         if (ld[c]) begin
            m_cnt[c] = (lv < KMIN) ? KMIN : ((lv > KMAX) ? KMAX : lv);
            m_tc[c]  = 0;
         end else if (en[c]) begin
            s   = dir[c] ? 1 : -1;
            raw = m_cnt[c] + s;
            m_tc[c] = (raw < KMIN || raw > KMAX) ? 1 : 0;
            if (sat[c])
               m_cnt[c] = (raw < KMIN) ? KMIN : ((raw > KMAX) ? KMAX : raw);
            else
               m_cnt[c] = ((raw - KMIN + R) % R) + KMIN;
         end else begin
            m_tc[c] = 0;
         end
      end
   endtask

   task automatic check_all(input string tag);
      int inr;
      inr = 1;
      for (int c = 0; c < NCH; c++) begin
         chk($sformatf("%s cnt%0d", tag, c), 32'(cnt[c*W +: W]), 32'(m_cnt[c]));
         chk($sformatf("%s tc%0d", tag, c), 32'(tc[c]), 32'(m_tc[c]));
         if (m_cnt[c] < KMIN || m_cnt[c] > KMAX) inr = 0;
      end
      chk($sformatf("%s prop", tag), 32'(prop), 32'(inr));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      #1;
      if (rst) model_reset();
      else     model_step();
      check_all(tag);
   endtask

   initial begin
      model_reset();
      // Reset held, then idle.
      repeat (3) cycle("rst_hold");
      rst = 1'b0;
      repeat (20) cycle("idle");

      // Channel 0 up with wrap for 15 steps.
      en[0] = 1'b1; dir[0] = 1'b1; sat[0] = 1'b0;
      tc0_seen = 0;
      for (int k = 0; k < 15; k++) begin
         cycle("up_wrap");
         tc0_seen += int'(tc[0]);
      end
      chk("up_wrap end cnt0", 32'(cnt[W-1:0]), 32'd1);
      chk("up_wrap end tc0", 32'(tc[0]), 32'd1);
      chk("up_wrap tc0 count", 32'(tc0_seen), 32'd1);
      en = '0;
      cycle("up_wrap idle");

      // Channel 1 load 2 then saturating down steps.
      ld[1] = 1'b1; ld_val[W +: W] = 4'd2;
      cycle("dn_sat load");
      ld[1] = 1'b0; en[1] = 1'b1; dir[1] = 1'b0; sat[1] = 1'b1;
      repeat (3) cycle("dn_sat");
      chk("dn_sat end tc1", 32'(tc[1]), 32'd1);
      en = '0;
      cycle("dn_sat idle");

      // Load clamp with simultaneous enable, then in-range load.
      ld[0] = 1'b1; en[0] = 1'b1; dir[0] = 1'b1; ld_val[0 +: W] = 4'd0;
      cycle("ld_clamp");
      chk("ld_clamp cnt0", 32'(cnt[W-1:0]), 32'd1);
      en[0] = 1'b0; ld_val[0 +: W] = 4'd14;
      cycle("ld_14");
      chk("ld_14 cnt0", 32'(cnt[W-1:0]), 32'd14);
      ld = '0;

      // Asynchronous reset between edges while channel 0 counts up from 9.
      ld[0] = 1'b1; ld_val[0 +: W] = 4'd9;
      cycle("pre_rst load");
      ld[0] = 1'b0; en[0] = 1'b1; dir[0] = 1'b1; sat[0] = 1'b0;
      cycle("pre_rst step");
      #2 rst = 1'b1;
      #1;
      model_reset();
      check_all("async_rst");
      chk("async_rst cnt0", 32'(cnt[W-1:0]), 32'd1);
      #1 rst = 1'b0;
      cycle("post_rst first edge");
      en = '0;

      // Randomized traffic.
      for (int k = 0; k < 400; k++) begin
         for (int c = 0; c < NCH; c++) begin
            ld[c]  = ($urandom_range(0, 7) == 0);
            en[c]  = ($urandom_range(0, 3) != 0);
            dir[c] = 1'($urandom_range(0, 1));
            sat[c] = 1'($urandom_range(0, 1));
            ld_val[c*W +: W] = 4'($urandom_range(0, 15));
         end
         cycle("random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
